// File: rtl/vector_alu_pipe.sv
// Two-stage pipelined scalar/vector ALU with a valid/ready handshake on both sides.
// Optional macro VALU_SAT_EN makes ADDV/SUBV saturate per lane instead of wrapping.
module vector_alu_pipe #(
  parameter int unsigned LANE_W = 8,
  parameter int unsigned LANES  = 4,
  localparam int unsigned WIDTH = LANE_W * LANES
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] SRC_A,
  input  logic [WIDTH-1:0] SRC_B,
  input  logic [3:0]       ALU_CONTROL,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] ALU_OUT,
  output logic             ALU_ERR
);

  typedef enum logic [3:0] {
    OP_ADD   = 4'h0, OP_SUB   = 4'h1, OP_MULT  = 4'h2, OP_XOR  = 4'h3,
    OP_ADDV  = 4'h4, OP_SUBV  = 4'h5, OP_XORV  = 4'h6, OP_SLV  = 4'h7,
    OP_SRV   = 4'h8, OP_SCLV  = 4'h9, OP_SCRV  = 4'hA, OP_MUXA = 4'hB,
    OP_MUXB  = 4'hC, OP_RSV0  = 4'hD, OP_RSV1  = 4'hE, OP_NOP  = 4'hF
  } op_e;

  localparam int unsigned RW    = $clog2(LANE_W);
  localparam int unsigned AMT_W = (WIDTH < 8) ? WIDTH : 8;

  logic             s1_valid_q;
  logic [WIDTH-1:0] a_q, b_q;
  op_e              op_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] res_q, res_d;
  logic             err_q, err_d;
  logic             en;

  logic [7:0]          amt;
  logic [RW-1:0]       rot;
  logic [WIDTH-1:0]    vec_res;
  logic [LANE_W-1:0]   la, lb, lane;
  logic [2*LANE_W-1:0] dbl;
`ifdef VALU_SAT_EN
  logic [LANE_W:0]     wide;
`endif

  assign en        = !out_valid_q || OUT_READY;
  assign IN_READY  = en;
  assign OUT_VALID = out_valid_q;
  assign ALU_OUT   = res_q;
  assign ALU_ERR   = err_q;

  assign amt = 8'(b_q[AMT_W-1:0]);
  assign rot = amt[RW-1:0];

  // Rotates shift a doubled copy of the lane so amount 0 needs no special case.
  always_comb begin
    vec_res = '0;
    la      = '0;
    lb      = '0;
    lane    = '0;
    dbl     = '0;
`ifdef VALU_SAT_EN
    wide    = '0;
`endif
    for (int unsigned i = 0; i < LANES; i++) begin
      la   = a_q[i*LANE_W +: LANE_W];
      lb   = b_q[i*LANE_W +: LANE_W];
      lane = '0;
      dbl  = '0;
      case (op_q)
`ifdef VALU_SAT_EN
        OP_ADDV: begin
          wide = {1'b0, la} + {1'b0, lb};
          lane = wide[LANE_W] ? '1 : wide[LANE_W-1:0];
        end
        OP_SUBV: lane = (la < lb) ? '0 : la - lb;
`else
        OP_ADDV: lane = la + lb;
        OP_SUBV: lane = la - lb;
`endif
        OP_XORV: lane = la ^ lb;
        OP_SLV:  lane = (32'(amt) >= LANE_W) ? '0 : la << amt;
        OP_SRV:  lane = (32'(amt) >= LANE_W) ? '0 : la >> amt;
        OP_SCLV: begin
          dbl  = {la, la} << rot;
          lane = dbl[2*LANE_W-1:LANE_W];
        end
        OP_SCRV: begin
          dbl  = {la, la} >> rot;
          lane = dbl[LANE_W-1:0];
        end
        default: lane = '0;
      endcase
      vec_res[i*LANE_W +: LANE_W] = lane;
    end
  end

  always_comb begin
    res_d = '0;
    err_d = 1'b0;
    case (op_q)
      OP_ADD:  res_d = a_q + b_q;
      OP_SUB:  res_d = a_q - b_q;
      OP_MULT: res_d = a_q * b_q;
      OP_XOR:  res_d = a_q ^ b_q;
      OP_ADDV, OP_SUBV, OP_XORV, OP_SLV, OP_SRV, OP_SCLV, OP_SCRV: res_d = vec_res;
      OP_MUXA: res_d = a_q;
      OP_MUXB: res_d = b_q;
      OP_RSV0, OP_RSV1: err_d = 1'b1;
      default: res_d = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      err_q       <= 1'b0;
    end else if (en) begin
      s1_valid_q  <= IN_VALID;
      out_valid_q <= s1_valid_q;
      // Bubbles load zero so the outputs read 0 whenever OUT_VALID is low.
      res_q       <= s1_valid_q ? res_d : '0;
      err_q       <= s1_valid_q & err_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST_N && en && IN_VALID) begin
      a_q  <= SRC_A;
      b_q  <= SRC_B;
      op_q <= op_e'(ALU_CONTROL);
    end
  end

endmodule

// File: tb/tb_vector_alu_pipe.sv
// Scoreboard bench for vector_alu_pipe: driver pushes expected results, monitor pops on each output beat.
module tb_vector_alu_pipe;
  localparam int LW = 8;
  localparam int NL = 4;
  localparam int W  = LW * NL;

  typedef struct {
    logic [W-1:0] res;
    logic         err;
  } exp_t;

  logic         CLK = 1'b0;
  logic         RST_N = 1'b0;
  logic         IN_VALID = 1'b0;
  logic         IN_READY;
  logic [W-1:0] SRC_A = '0;
  logic [W-1:0] SRC_B = '0;
  logic [3:0]   ALU_CONTROL = '0;
  logic         OUT_VALID;
  logic         OUT_READY = 1'b0;
  logic [W-1:0] ALU_OUT;
  logic         ALU_ERR;

  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];
  bit   rand_rdy = 1'b0;
  bit   fixed_rdy = 1'b1;

  vector_alu_pipe #(.LANE_W(LW), .LANES(NL)) dut (
    .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .SRC_A(SRC_A), .SRC_B(SRC_B), .ALU_CONTROL(ALU_CONTROL),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .ALU_OUT(ALU_OUT), .ALU_ERR(ALU_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input bit ok, input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op);
    exp_t e;
    longint unsigned la, lb, r, k, amt, mask;
    mask  = (64'd1 << LW) - 1;
    amt   = 64'(b[7:0]);
    k     = amt % LW;
    e.res = '0;
    e.err = 1'b0;
    case (op)
      4'd0: e.res = a + b;
      4'd1: e.res = a - b;
      4'd2: e.res = W'(64'(a) * 64'(b));
      4'd3: e.res = a ^ b;
      4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10:
        for (int i = 0; i < NL; i++) begin
          la = (64'(a) >> (i * LW)) & mask;
          lb = (64'(b) >> (i * LW)) & mask;
          case (op)
`ifdef VALU_SAT_EN
            4'd4: r = (la + lb > mask) ? mask : la + lb;
            4'd5: r = (la < lb) ? 0 : la - lb;
`else
            4'd4: r = (la + lb) % (mask + 1);
            4'd5: r = (la + mask + 1 - lb) % (mask + 1);
`endif
            4'd6: r = la ^ lb;
            4'd7: r = (amt >= LW) ? 0 : (la * (64'd1 << amt)) % (mask + 1);
            4'd8: r = (amt >= LW) ? 0 : la / (64'd1 << amt);
            4'd9: r = ((la << k) | (la >> (LW - k))) & mask;
            default: r = ((la >> k) | (la << (LW - k))) & mask;
          endcase
          e.res[i*LW +: LW] = r[LW-1:0];
        end
      4'd11: e.res = a;
      4'd12: e.res = b;
      4'd13, 4'd14: e.err = 1'b1;
      default: e.res = '0;
    endcase
    return e;
  endfunction

  // One cycle: inputs applied after the edge, handshake sampled at the falling edge.
  task automatic step(input bit v, input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op,
                      input exp_t e, output bit acc, output bit rdy, output bit ov);
    IN_VALID    = v;
    SRC_A       = a;
    SRC_B       = b;
    ALU_CONTROL = op;
    OUT_READY   = rand_rdy ? ($urandom_range(0, 9) < 7) : fixed_rdy;
    @(negedge CLK);
    rdy = IN_READY;
    ov  = OUT_VALID;
    acc = v && IN_READY && RST_N;
    if (acc) exp_q.push_back(e);
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    exp_t e;
    bit acc, rdy, ov;
    e.res = '0;
    e.err = 1'b0;
    repeat (n) step(1'b0, '0, '0, 4'd0, e, acc, rdy, ov);
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op, input exp_t e);
    bit acc, rdy, ov;
    int n;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 100) begin
      step(1'b1, a, b, op, e, acc, rdy, ov);
      n++;
    end
    if (!acc) chk(1'b0, "accept_timeout", W'(n), W'(100));
    IN_VALID = 1'b0;
  endtask

  task automatic drain();
    int n;
    rand_rdy  = 1'b0;
    fixed_rdy = 1'b1;
    n = 0;
    while (exp_q.size() > 0 && n < 50) begin
      idle(1);
      n++;
    end
    idle(2);
    chk(exp_q.size() == 0, "drain", W'(exp_q.size()), '0);
  endtask

  function automatic exp_t mk(input logic [W-1:0] r, input logic er);
    exp_t e;
    e.res = r;
    e.err = er;
    return e;
  endfunction

  // Monitor: compares every taken output beat and checks hold/idle behaviour.
  initial begin
    bit           held;
    logic [W-1:0] h_res;
    logic         h_err;
    exp_t         e;
    held = 1'b0;
    forever begin
      @(negedge CLK);
      if (!RST_N) begin
        held = 1'b0;
      end else if (OUT_VALID) begin
        if (held) begin
          chk(ALU_OUT == h_res && ALU_ERR == h_err, "stall_stable", ALU_OUT, h_res);
        end
        if (OUT_READY) begin
          held = 1'b0;
          if (exp_q.size() == 0) begin
            chk(1'b0, "unexpected_output", ALU_OUT, '0);
          end else begin
            e = exp_q.pop_front();
            chk(ALU_OUT == e.res, "result", ALU_OUT, e.res);
            chk(ALU_ERR == e.err, "err_flag", W'(ALU_ERR), W'(e.err));
          end
        end else begin
          held  = 1'b1;
          h_res = ALU_OUT;
          h_err = ALU_ERR;
        end
      end else begin
        if (held) chk(1'b0, "stalled_beat_lost", '0, W'(1));
        held = 1'b0;
        chk(ALU_OUT == '0 && ALU_ERR == 1'b0, "idle_zero", ALU_OUT, '0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit           acc, rdy, ov;
    logic [W-1:0] a, b;
    logic [3:0]   op;
    exp_t         z;
    z = mk('0, 1'b0);

    // Reset state
    @(posedge CLK);
    #1;
    RST_N = 1'b0;
    idle(2);
    chk(OUT_VALID == 1'b0, "rst_out_valid", W'(OUT_VALID), '0);
    chk(ALU_OUT == '0 && ALU_ERR == 1'b0, "rst_out_zero", ALU_OUT, '0);
    chk(IN_READY == 1'b1, "rst_in_ready", W'(IN_READY), W'(1));
    RST_N = 1'b1;
    idle(1);

    // Latency 2 with a single ADDV beat
    fixed_rdy = 1'b1;
`ifdef VALU_SAT_EN
    step(1'b1, 32'h01FF7F80, 32'h01010101, 4'd4, mk(32'h02FF8081, 1'b0), acc, rdy, ov);
`else
    step(1'b1, 32'h01FF7F80, 32'h01010101, 4'd4, mk(32'h02008081, 1'b0), acc, rdy, ov);
`endif
    chk(acc, "lat_accept", W'(acc), W'(1));
    chk(OUT_VALID == 1'b0, "lat_edge1", W'(OUT_VALID), '0);
    idle(1);
    chk(OUT_VALID == 1'b1, "lat_edge2", W'(OUT_VALID), W'(1));
    drain();

    // Directed lane ops
    send(32'h81C30F01, 32'd3, 4'd9,  mk(32'h0C1E7808, 1'b0));
    send(32'h81C30F01, 32'd3, 4'd10, mk(32'h3078E120, 1'b0));
    send(32'h81C30F01, 32'd9, 4'd7,  mk(32'h00000000, 1'b0));
    send(32'h81C30F01, 32'd0, 4'd9,  mk(32'h81C30F01, 1'b0));
    send(32'h00000000, 32'h11223344, 4'd6, mk(32'h11223344, 1'b0));
    send(32'hDEADBEEF, 32'h12345678, 4'd13, mk(32'h0, 1'b1));
    send(32'hDEADBEEF, 32'h12345678, 4'd14, mk(32'h0, 1'b1));
    send(32'hDEADBEEF, 32'h12345678, 4'd15, mk(32'h0, 1'b0));
    send(32'hF0F0F0F0, 32'd4, 4'd8,  mk(32'h0F0F0F0F, 1'b0));
    drain();

    // Backpressure: two accepts, third held, then one output per cycle
    fixed_rdy = 1'b0;
    send(32'd1, 32'd1, 4'd0, mk(32'd2, 1'b0));
    send(32'd2, 32'd2, 4'd0, mk(32'd4, 1'b0));
    step(1'b1, 32'd3, 32'd3, 4'd0, mk(32'd6, 1'b0), acc, rdy, ov);
    chk(rdy == 1'b0, "bp_in_ready_low", W'(rdy), '0);
    chk(acc == 1'b0, "bp_held_upstream", W'(acc), '0);
    fixed_rdy = 1'b1;
    step(1'b1, 32'd3, 32'd3, 4'd0, mk(32'd6, 1'b0), acc, rdy, ov);
    chk(acc && ov, "bp_release_accept", W'({acc, ov}), W'(3));
    step(1'b0, '0, '0, 4'd0, z, acc, rdy, ov);
    chk(ov == 1'b1, "bp_thru_2", W'(ov), W'(1));
    step(1'b0, '0, '0, 4'd0, z, acc, rdy, ov);
    chk(ov == 1'b1, "bp_thru_3", W'(ov), W'(1));
    drain();

    // Reset with S1 and S2 occupied; a beat offered during reset must not be taken
    fixed_rdy = 1'b0;
    send(32'd5, 32'd5, 4'd0, mk(32'd10, 1'b0));
    send(32'd6, 32'd6, 4'd0, mk(32'd12, 1'b0));
    fixed_rdy = 1'b1;
    RST_N = 1'b0;
    step(1'b1, 32'd7, 32'd7, 4'd0, mk(32'd14, 1'b0), acc, rdy, ov);
    chk(rdy == 1'b1, "rst_ready_follows_en", W'(rdy), W'(1));
    RST_N = 1'b1;
    exp_q.delete();
    IN_VALID = 1'b0;
    chk(OUT_VALID == 1'b0, "rst_flush_valid", W'(OUT_VALID), '0);
    chk(ALU_OUT == '0, "rst_flush_out", ALU_OUT, '0);
    idle(4);
    chk(OUT_VALID == 1'b0, "rst_no_ghost", W'(OUT_VALID), '0);
    send(32'd8, 32'd8, 4'd0, mk(32'd16, 1'b0));
    drain();

    // Random traffic with random backpressure
    rand_rdy = 1'b1;
    for (int n = 0; n < 400; n++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = ($urandom_range(0, 1) == 1) ? $urandom : W'($urandom_range(0, 12));
      if ($urandom_range(0, 3) == 0) idle(1);
      send(a, b, op, model(a, b, op));
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vector_alu_pipe.md
VECTOR_ALU_PIPE -- requirements
Module: vector_alu_pipe

Interface
REQ-001 The block SHALL have parameter LANE_W, default 8, giving the bits per vector lane (power of two, 4..32).
REQ-002 The block SHALL have parameter LANES, default 4, giving the number of vector lanes (1..8).
REQ-003 The block SHALL use derived localparam WIDTH = LANE_W*LANES as the operand and result width.
REQ-004 The block SHALL have one clock; reset is synchronous and active-low.
REQ-005 CLK  input  1  rising-edge clock for all state.
REQ-006 RST_N  input  1  synchronous active-low reset.
REQ-007 IN_VALID  input  1  operand/op beat offered.
REQ-008 IN_READY  output  1  block accepts beat this cycle.
REQ-009 SRC_A  input  WIDTH  operand A.
REQ-010 SRC_B  input  WIDTH  operand B, or shift/rotate amount.
REQ-011 ALU_CONTROL  input  4  opcode.
REQ-012 OUT_VALID  output  1  result beat present.
REQ-013 OUT_READY  input  1  consumer takes result.
REQ-014 ALU_OUT  output  WIDTH  result.
REQ-015 ALU_ERR  output  1  unsupported opcode flag, qualified by OUT_VALID.

Function
REQ-016 Opcodes SHALL be: 0000 ADD, 0001 SUB, 0010 MULT (low WIDTH bits), 0011 XOR, 0100 ADDV, 0101 SUBV, 0110 XORV, 0111 SLV, 1000 SRV, 1001 SCLV, 1010 SCRV, 1011 MUX_A, 1100 MUX_B, 1111 NOP (result 0).
REQ-017 Vector ops SHALL act lane-wise, lane i = bits [i*LANE_W +: LANE_W] of A and B; XORV uses lane i of B, not lane 0; no carry or borrow crosses lanes.
REQ-018 SLV/SRV SHALL logically shift every A lane by unsigned SRC_B[7:0]; an amount >= LANE_W gives lane value 0.
REQ-019 SCLV/SCRV SHALL rotate every A lane left/right by SRC_B[7:0] mod LANE_W; amount 0 returns A unchanged.
REQ-020 Opcodes 1101 and 1110 SHALL give ALU_OUT 0 and ALU_ERR 1; every other opcode gives ALU_ERR 0.
REQ-021 Pipeline SHALL have two register stages: S1 captures operands and opcode, S2 captures result; each stage has its own valid bit.
REQ-022 Global advance enable SHALL be EN = !OUT_VALID || OUT_READY; IN_READY = EN, combinational from OUT_VALID and OUT_READY only.
REQ-023 Beat SHALL be accepted on a rising edge with IN_VALID && IN_READY; its result appears with OUT_VALID at the second following edge when EN stays high (latency 2).
REQ-024 When EN is low, S1 and S2 (data and valid) SHALL hold; ALU_OUT and ALU_ERR stay stable while OUT_VALID && !OUT_READY.
REQ-025 When EN is high and IN_VALID is low, S1 valid SHALL load 0 (bubble), and the bubble propagates to S2.
REQ-026 Results SHALL leave in acceptance order; no beat is dropped or duplicated under any IN_VALID/OUT_READY pattern.
REQ-027 Simultaneous output take and input accept in one cycle SHALL sustain one beat per cycle throughput.
REQ-028 ALU_OUT and ALU_ERR SHALL be 0 whenever OUT_VALID is 0.

Reset
REQ-029 With RST_N low at a rising edge, S1/S2 valids, ALU_OUT and ALU_ERR SHALL clear to 0; OUT_VALID is 0 from that edge on.
REQ-030 Reset mid-operation SHALL discard all in-flight beats; no result for them ever appears.
REQ-031 While RST_N is low, IN_READY SHALL still follow REQ-022, but no beat is accepted.

Configuration
REQ-032 With macro VALU_SAT_EN defined, ADDV SHALL clamp each lane to all-ones on unsigned overflow and SUBV SHALL clamp to 0 on underflow.
REQ-033 Without VALU_SAT_EN, ADDV/SUBV SHALL wrap modulo 2^LANE_W and no saturation logic exists.

Verification (defaults LANE_W=8, LANES=4)
REQ-034 ADDV A=0x01FF7F80 B=0x01010101, OUT_READY=1 -> ALU_OUT 0x02008081 two edges after accept; 0x02FF8081 with VALU_SAT_EN.
REQ-035 SCLV A=0x81C30F01 B=3 -> 0x0C1E7808; SCRV same A, B=3 -> 0x3078E120; SLV B=9 -> 0x00000000.
REQ-036 XORV A=0x00000000 B=0x11223344 -> 0x11223344 (per-lane B); opcode 1101 -> ALU_OUT 0, ALU_ERR 1.
REQ-037 Three back-to-back beats ADD 1+1, 2+2, 3+3 with OUT_READY low for 3 cycles -> IN_READY drops after two accepts, third beat held upstream; on release, outputs 2, 4, 6 in order, one per cycle.
REQ-038 RST_N low one cycle while OUT_VALID=1 and S1 full -> OUT_VALID 0 next edge and stays 0 until a new beat is accepted; ALU_OUT 0.
